// File: rtl/mem_access_stage.sv
// Memory stage: word loads/stores over a req/gnt/rvalid bus, stalling the pipe while an access is open.
// Define MEM_TIMEOUT_EN to force-complete accesses that wait TIMEOUT_CYCLES cycles and raise MemErrM.
module mem_access_stage #(
   parameter int WIDTH          = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ValidM,
   input  logic             PCSrcMIn,
   input  logic             RegWriteMIn,
   input  logic             MemtoRegMIn,
   input  logic             MemWriteM,
   input  logic [WIDTH-1:0] ALUResultM,
   input  logic [WIDTH-1:0] WriteDataM,
   input  logic [3:0]       WA3MIn,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_gnt,
   input  logic             mem_rvalid,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             StallM,
   output logic             PCSrcM,
   output logic             RegWriteM,
   output logic             MemtoRegM,
   output logic [WIDTH-1:0] ReadDataM,
   output logic [WIDTH-1:0] ALUOutM,
   output logic [3:0]       WA3M,
   output logic             MemErrM
);

   // state    | meaning
   // IDLE     | no access outstanding; a memop requests immediately
   // WAIT_GNT | request presented, bus has not granted yet
   // WAIT_RSP | load granted, waiting for rvalid
   typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_t;

   state_t           state, state_nxt;
   logic             memop, done, rsp_take, waiting, timeout, req_raw;
   logic [WIDTH-1:0] rdata_q;

   assign memop   = ValidM & (MemtoRegMIn | MemWriteM);
   assign waiting = ((state == WAIT_GNT) & memop) | (state == WAIT_RSP);

   always_comb begin
      state_nxt = state;
      req_raw   = 1'b0;
      done      = ~memop;
      rsp_take  = 1'b0;
      case (state)
         WAIT_RSP: begin
            if (mem_rvalid) begin
               rsp_take  = 1'b1;
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            req_raw = memop;
            if (!memop)
               state_nxt = IDLE;
            else if (mem_gnt) begin
               if (MemWriteM) begin
                  done      = 1'b1;
                  state_nxt = IDLE;
               end else
                  state_nxt = WAIT_RSP;
            end else
               state_nxt = WAIT_GNT;
         end
      endcase
      if (timeout) begin
         done      = 1'b1;
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         rdata_q <= '0;
      end else begin
         state <= state_nxt;
         if (rsp_take)
            rdata_q <= mem_rdata;
         else if (timeout & ~MemWriteM)
            rdata_q <= '0;
      end
   end

`ifdef MEM_TIMEOUT_EN
   localparam int                CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]     CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] cnt;
   logic          err_q;

   assign timeout = waiting & (cnt == CNT_LAST);
   assign MemErrM = err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         if (!waiting || done || state_nxt == IDLE)
            cnt <= '0;
         else
            cnt <= cnt + CW'(1);
         if (timeout)
            err_q <= 1'b1;
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0) & waiting;
   assign timeout            = 1'b0;
   assign MemErrM            = 1'b0;
`endif

   // Reset also drops the request combinationally so the bus sees no access while reset is held.
   assign mem_req   = req_raw & ~reset;
   assign mem_we    = MemWriteM;
   assign mem_addr  = ALUResultM;
   assign mem_wdata = WriteDataM;

   assign StallM    = memop & ~done;
   assign RegWriteM = RegWriteMIn & ~StallM;
   assign PCSrcM    = PCSrcMIn & ~StallM;
   assign MemtoRegM = MemtoRegMIn & ~StallM;
   assign ReadDataM = rsp_take ? mem_rdata : ((timeout & ~MemWriteM) ? '0 : rdata_q);
   assign ALUOutM   = ALUResultM;
   assign WA3M      = WA3MIn;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus random transactions against a transaction-level model.
module tb_mem_access_stage;
   localparam int W = 32;

   logic         clk, reset;
   logic         ValidM, PCSrcMIn, RegWriteMIn, MemtoRegMIn, MemWriteM;
   logic [W-1:0] ALUResultM, WriteDataM;
   logic [3:0]   WA3MIn;
   logic         mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
   logic         StallM, PCSrcM, RegWriteM, MemtoRegM, MemErrM;
   logic [W-1:0] ReadDataM, ALUOutM;
   logic [3:0]   WA3M;

   int           vectors = 0;
   int           errors  = 0;
   logic [W-1:0] last_load = '0;
   int           nreq, nstall, nwb;

   mem_access_stage #(.WIDTH(W), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .ValidM(ValidM), .PCSrcMIn(PCSrcMIn),
      .RegWriteMIn(RegWriteMIn), .MemtoRegMIn(MemtoRegMIn), .MemWriteM(MemWriteM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3MIn(WA3MIn),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .StallM(StallM), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
      .ReadDataM(ReadDataM), .ALUOutM(ALUOutM), .WA3M(WA3M), .MemErrM(MemErrM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive_idle();
      ValidM = 0; PCSrcMIn = 0; RegWriteMIn = 0; MemtoRegMIn = 0; MemWriteM = 0;
      ALUResultM = '0; WriteDataM = '0; WA3MIn = '0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
   endtask

   // kind: 0 = non-memory op, 1 = store, 2 = load. g = cycles before gnt, r = extra cycles after gnt before rvalid.
   task automatic run_txn(input int kind, input int g, input int r, input logic [W-1:0] addr,
                          input logic [W-1:0] wdata, input logic [W-1:0] rdata, input logic rw);
      int last;
      logic exp_stall, exp_req;
      logic [W-1:0] exp_rd;
      nreq = 0; nstall = 0; nwb = 0;
      RegWriteMIn = rw;
      PCSrcMIn    = 1'($urandom);
      WA3MIn      = 4'($urandom);
      ALUResultM  = addr;
      WriteDataM  = wdata;
      if (kind == 0) begin
         ValidM = 1'($urandom);
         MemWriteM   = ValidM ? 1'b0 : 1'($urandom);
         MemtoRegMIn = ValidM ? 1'b0 : 1'($urandom);
      end else begin
         ValidM      = 1'b1;
         MemWriteM   = (kind == 1);
         MemtoRegMIn = (kind == 2) | ((kind == 1) & 1'($urandom));
      end
      last = (kind == 0) ? 0 : ((kind == 1) ? g : g + 1 + r);
      for (int k = 0; k <= last; k++) begin
         mem_gnt = (kind != 0) && (k == g);
         if (kind == 2)
            mem_rvalid = (k == last) ? 1'b1 : ((k <= g) ? 1'($urandom) : 1'b0);
         else
            mem_rvalid = 1'($urandom);
         mem_rdata = (kind == 2 && k == last) ? rdata : $urandom;
         #4;
         exp_stall = (k < last);
         exp_req   = (kind != 0) && (k <= g);
         exp_rd    = (kind == 2 && k == last) ? rdata : last_load;
         chk("req", W'(mem_req), W'(exp_req));
         chk("stall", W'(StallM), W'(exp_stall));
         chk("regwrite", W'(RegWriteM), W'(RegWriteMIn & ~exp_stall));
         chk("pcsrc", W'(PCSrcM), W'(PCSrcMIn & ~exp_stall));
         chk("memtoreg", W'(MemtoRegM), W'(MemtoRegMIn & ~exp_stall));
         chk("rdata", ReadDataM, exp_rd);
         chk("aluout", ALUOutM, addr);
         chk("wa3", W'(WA3M), W'(WA3MIn));
         chk("memerr", W'(MemErrM), '0);
         if (exp_req) begin
            chk("we", W'(mem_we), W'(kind == 1));
            chk("addr", mem_addr, addr);
            chk("wdata", mem_wdata, wdata);
         end
         nreq   += int'(mem_req);
         nstall += int'(StallM);
         nwb    += int'(RegWriteM);
         @(posedge clk);
         if (kind == 2 && k == last) last_load = rdata;
         @(negedge clk);
      end
      drive_idle();
   endtask

   initial begin
      drive_idle();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #4;
      chk("rst_req", W'(mem_req), '0);
      chk("rst_rdata", ReadDataM, '0);
      @(negedge clk);
      reset = 1'b0;
      #4;
      chk("rel_req", W'(mem_req), '0);
      chk("rel_stall", W'(StallM), '0);
      chk("rel_rdata", ReadDataM, '0);
      chk("rel_memerr", W'(MemErrM), '0);
      @(negedge clk);

      run_txn(1, 0, 0, 32'h40, 32'hDEADBEEF, '0, 1'b1);
      chk("store_wb", W'(nwb), W'(1));
      run_txn(2, 0, 0, 32'h80, '0, 32'h12345678, 1'b1);
      chk("load_stalls", W'(nstall), W'(1));
      run_txn(2, 3, 1, 32'hC0, '0, 32'hCAFEF00D, 1'b1);
      chk("dly_req_cycles", W'(nreq), W'(4));
      chk("dly_stall_cycles", W'(nstall), W'(5));
      chk("dly_writebacks", W'(nwb), W'(1));

      for (int i = 0; i < 150; i++)
         run_txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                 $urandom, $urandom, $urandom, 1'($urandom));

      // reset while a load waits for its response, then a stray rvalid
      ValidM = 1; MemtoRegMIn = 1; RegWriteMIn = 1; ALUResultM = 32'h100; mem_gnt = 1;
      @(posedge clk); @(negedge clk);
      mem_gnt = 0;
      #4;
      chk("mid_stall", W'(StallM), W'(1));
      @(negedge clk);
      reset = 1'b1; ValidM = 0; MemtoRegMIn = 0; RegWriteMIn = 0;
      #1;
      chk("mid_rst_req", W'(mem_req), '0);
      chk("mid_rst_stall", W'(StallM), '0);
      last_load = '0;
      @(negedge clk);
      reset = 1'b0;
      mem_rvalid = 1; mem_rdata = 32'hAAAA5555;
      #4;
      chk("stray_rdata", ReadDataM, '0);
      chk("stray_stall", W'(StallM), '0);
      @(negedge clk);
      mem_rvalid = 0;
      #4;
      chk("stray_capture", ReadDataM, '0);
      @(negedge clk);

`ifdef MEM_TIMEOUT_EN
      ValidM = 1; MemtoRegMIn = 1; RegWriteMIn = 1; ALUResultM = 32'h200;
      for (int k = 0; k <= 8; k++) begin
         #4;
         chk("to_stall", W'(StallM), W'(k < 8));
         if (k == 8) begin
            chk("to_rdata", ReadDataM, '0);
            chk("to_regwrite", W'(RegWriteM), W'(1));
         end
         @(negedge clk);
      end
      drive_idle();
      for (int k = 0; k < 3; k++) begin
         #4;
         chk("to_memerr", W'(MemErrM), W'(1));
         chk("to_rdata_after", ReadDataM, '0);
         @(negedge clk);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
